floppy_seek_ctrl: RTL

Head-positioning controller for the PC-style floppy interface behind the IEC front end. It accepts seek and recalibrate commands and generates the drive-select, DIR and STEP sequence with programmable timing. It tracks head position and calibration state per drive, and reports completion or error. It sits between the command decoder and the floppy pin drivers; the top level applies pin polarity inversion.

---
 rtl/floppy_seek_ctrl_if.sv | 33 +++
 rtl/floppy_seek_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/floppy_seek_ctrl_if.sv
// Command and pin bundle for the floppy head-positioning controller.
// master: command decoder / drive side, slave: the seek controller.
interface floppy_seek_ctrl_if #(
  parameter int unsigned DRV_W   = 1,
  parameter int unsigned TRACK_W = 7
);
  localparam int unsigned NUM_DRIVES = 2**DRV_W;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_recal;
  logic [DRV_W-1:0]      cmd_drive;
  logic [TRACK_W-1:0]    cmd_track;
  logic                  trk00;
  logic [NUM_DRIVES-1:0] drv_sel;
  logic                  dir;
  logic                  step;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [TRACK_W-1:0]    cur_track;
  logic [NUM_DRIVES-1:0] calibrated;

  modport master (
    output cmd_valid, cmd_recal, cmd_drive, cmd_track, trk00,
    input  cmd_ready, drv_sel, dir, step, busy, done, err, cur_track, calibrated
  );

  modport slave (
    input  cmd_valid, cmd_recal, cmd_drive, cmd_track, trk00,
    output cmd_ready, drv_sel, dir, step, busy, done, err, cur_track, calibrated
  );
endinterface

// File: rtl/floppy_seek_ctrl.sv
// Floppy head-positioning controller: accepts seek/recalibrate commands,
// sequences drive select, DIR and STEP with programmable timing, and keeps
// per-drive track position and calibration state.
module floppy_seek_ctrl #(
  parameter int unsigned DRV_W          = 1,
  parameter int unsigned TRACK_W        = 7,
  parameter int unsigned MAX_TRACK      = 83,
  parameter int unsigned STEP_PULSE_CYC = 100,
  parameter int unsigned STEP_RATE_CYC  = 150000,
  parameter int unsigned DIR_SETUP_CYC  = 50,
  parameter int unsigned SETTLE_CYC     = 750000,
  parameter int unsigned RECAL_MAX      = 90
) (
  input logic               clk,
  input logic               RESET_IN,
  floppy_seek_ctrl_if.slave bus
);

  localparam int unsigned NUM_DRIVES = 2**DRV_W;
  localparam int unsigned LO_CYC     = STEP_RATE_CYC - STEP_PULSE_CYC;
  localparam int unsigned CNT_MAX0   = (SETTLE_CYC > STEP_RATE_CYC) ? SETTLE_CYC : STEP_RATE_CYC;
  localparam int unsigned CNT_MAX    = (CNT_MAX0 > DIR_SETUP_CYC) ? CNT_MAX0 : DIR_SETUP_CYC;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned SC_W       = $clog2(RECAL_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_END  = CNT_W'(DIR_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HI_END     = CNT_W'(STEP_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LO_END     = CNT_W'(LO_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SC_W-1:0]  SC_LIMIT   = SC_W'(RECAL_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP_HI,
    S_STEP_LO,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [SC_W-1:0]       r_step_cnt;
  logic [DRV_W-1:0]      r_drive;
  logic [TRACK_W-1:0]    r_target;
  logic                  r_recal;
  logic                  r_dir;
  logic                  r_step;
  logic                  r_busy;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_err;
  logic                  r_err_pend;
  logic [NUM_DRIVES-1:0] r_drv_sel;
  logic [NUM_DRIVES-1:0] r_cal;
  logic [TRACK_W-1:0]    r_track [NUM_DRIVES];

  logic                  w_accept;
  logic [TRACK_W-1:0]    w_cur;
  logic [TRACK_W-1:0]    w_acc_cur;
  logic                  w_acc_bad;
  logic                  w_acc_same;
  logic [NUM_DRIVES-1:0] w_acc_sel;
  logic                  w_decide;
  state_t                w_dec_state;
  logic                  w_dec_zero;
  logic                  w_dec_setcal;
  logic                  w_dec_clrcal;
  logic                  w_dec_errpend;

  assign w_accept   = bus.cmd_valid & r_ready;
  assign w_cur      = r_track[r_drive];
  assign w_acc_cur  = r_track[bus.cmd_drive];
  assign w_acc_bad  = ~bus.cmd_recal &
                      ((32'(bus.cmd_track) > MAX_TRACK) | ~r_cal[bus.cmd_drive]);
  assign w_acc_same = ~bus.cmd_recal & (bus.cmd_track == w_acc_cur);
  assign w_acc_sel  = NUM_DRIVES'(1) << bus.cmd_drive;
  assign w_decide   = ((r_state == S_SETUP)   && (r_cnt == SETUP_END)) ||
                      ((r_state == S_STEP_LO) && (r_cnt == LO_END));

  // Step decision taken when SETUP or STEP_LO completes.
  always_comb begin
    w_dec_state   = S_STEP_HI;
    w_dec_zero    = 1'b0;
    w_dec_setcal  = 1'b0;
    w_dec_clrcal  = 1'b0;
    w_dec_errpend = 1'b0;
    if (r_recal) begin
      if (bus.trk00) begin
        w_dec_state  = S_SETTLE;
        w_dec_zero   = 1'b1;
        w_dec_setcal = 1'b1;
      end else if (r_step_cnt == SC_LIMIT) begin
        w_dec_state  = S_DONE;
        w_dec_clrcal = 1'b1;
      end
    end else begin
      if (w_cur == r_target) begin
        w_dec_state = S_SETTLE;
      end else if (!r_dir && bus.trk00 && (w_cur != '0)) begin
        // Head reached track 0 earlier than the register expected: resync.
        w_dec_state   = S_SETTLE;
        w_dec_zero    = 1'b1;
        w_dec_errpend = 1'b1;
      end
    end
  end

  // Main sequencer: state, timers, track/calibration registers, pin outputs.
  always_ff @(posedge clk or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_step_cnt <= '0;
      r_drive    <= '0;
      r_target   <= '0;
      r_recal    <= 1'b0;
      r_dir      <= 1'b0;
      r_step     <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_pend <= 1'b0;
      r_drv_sel  <= '0;
      r_cal      <= '0;
      for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
        r_track[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_drive    <= bus.cmd_drive;
            r_target   <= bus.cmd_track;
            r_recal    <= bus.cmd_recal;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_drv_sel  <= w_acc_sel;
            r_err_pend <= 1'b0;
            r_cnt      <= '0;
            r_step_cnt <= '0;
            if (w_acc_bad) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (w_acc_same) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_dir   <= ~bus.cmd_recal & (bus.cmd_track > w_acc_cur);
            end
          end
        end

        S_SETUP, S_STEP_LO: begin
          if (w_decide) begin
            r_cnt   <= '0;
            r_state <= w_dec_state;
            if (w_dec_state == S_STEP_HI) r_step <= 1'b1;
            if (w_dec_zero)    r_track[r_drive] <= '0;
            if (w_dec_setcal)  r_cal[r_drive]   <= 1'b1;
            if (w_dec_clrcal)  r_cal[r_drive]   <= 1'b0;
            if (w_dec_errpend) r_err_pend       <= 1'b1;
            if (w_dec_state == S_DONE) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_STEP_HI: begin
          if (r_cnt == HI_END) begin
            r_cnt      <= '0;
            r_step     <= 1'b0;
            r_state    <= S_STEP_LO;
            r_step_cnt <= r_step_cnt + SC_W'(1);
            if (!r_recal) begin
              if (r_dir) begin
                if (w_cur != '1) r_track[r_drive] <= w_cur + TRACK_W'(1);
              end else begin
                if (w_cur != '0) r_track[r_drive] <= w_cur - TRACK_W'(1);
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_SETTLE: begin
          if (r_cnt == SETTLE_END) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= r_err_pend;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_ready   <= 1'b1;
          r_drv_sel <= '0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = r_ready;
  assign bus.drv_sel    = r_drv_sel;
  assign bus.dir        = r_dir;
  assign bus.step       = r_step;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.cur_track  = w_cur;
  assign bus.calibrated = r_cal;

endmodule
